freq_meter: RTL

Equal-precision (reciprocal) frequency meter that measures an external signal against the system clock and produces the 64-bit frequency word `data_fx` in Hz. It sits directly upstream of the ADC sample-clock selector, which compares `data_fx` against the 100 Hz and 100 kHz band thresholds. Measurement runs continuously: each completed gate updates `data_fx` and pulses `data_valid`.

---
 rtl/freq_meter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/freq_meter.sv
// freq_meter: equal-precision (reciprocal) frequency meter.
//
// Opens a gate on a rising edge of sig_in, holds it for at least GATE_CYCLES
// reference cycles, then closes it on the next rising edge. The gate therefore
// spans n_sig whole signal periods and n_ref reference cycles. The frequency is
// computed as n_sig * CLK_FREQ / n_ref by a 64-cycle restoring divider.
// A missing edge (DC or absent input) times out after 2*GATE_CYCLES cycles and
// reports 0 Hz.
//
// Optional build macro:
//   FREQ_METER_ROUND_EN  round the quotient to nearest instead of truncating.
//
// Parameters:
//   CLK_FREQ     frequency of clk in Hz (< 2^32)
//   GATE_CYCLES  minimum gate length in clk cycles (2 .. 2^30)
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-low reset
//   sig_in      measured signal, asynchronous to clk
//   data_fx     last measured frequency in Hz, held between updates
//   data_valid  one-cycle pulse when data_fx is updated
//   busy        high while a measurement or division is in progress

module freq_meter #(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned GATE_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sig_in,
  output logic [63:0] data_fx,
  output logic        data_valid,
  output logic        busy
);

  localparam int unsigned GateW = 30;
  localparam int unsigned ToW   = 31;
  localparam logic [GateW-1:0] GateLast = GateW'(GATE_CYCLES - 1);
  localparam logic [ToW-1:0]   ToLast   = ToW'(2 * GATE_CYCLES - 1);

  typedef enum logic [2:0] {
    StWaitStart,
    StMeasure,
    StWaitStop,
    StDivide,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        sync_q;
  logic              sig_rise_q;
  logic [31:0]       n_ref_q, n_ref_d;
  logic [31:0]       n_sig_q, n_sig_d;
  logic [GateW-1:0]  gate_cnt_q, gate_cnt_d;
  logic [ToW-1:0]    to_cnt_q, to_cnt_d;
  logic [63:0]       num_q, num_d;       // dividend shifts out MSB-first, quotient shifts in
  logic [31:0]       rem_q, rem_d;
  logic [31:0]       den_q, den_d;
  logic [5:0]        bit_cnt_q, bit_cnt_d;
  logic [63:0]       data_fx_q, data_fx_d;

  // Restoring divider step. The remainder is always below den (< 2^32), so
  // 33 bits cover the shifted partial remainder.
  logic [32:0]       rem_shift;
  logic              q_bit;
  logic [31:0]       rem_next;
  logic [63:0]       num_next;

  always_comb begin
    rem_shift = {rem_q, num_q[63]};
    q_bit     = (rem_shift >= {1'b0, den_q});
    rem_next  = q_bit ? 32'(rem_shift - {1'b0, den_q}) : rem_shift[31:0];
    num_next  = {num_q[62:0], q_bit};
  end

  always_comb begin
    state_d    = state_q;
    n_ref_d    = n_ref_q;
    n_sig_d    = n_sig_q;
    gate_cnt_d = gate_cnt_q;
    to_cnt_d   = to_cnt_q;
    num_d      = num_q;
    rem_d      = rem_q;
    den_d      = den_q;
    bit_cnt_d  = bit_cnt_q;
    data_fx_d  = data_fx_q;

    unique case (state_q)
      StWaitStart: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (sig_rise_q) begin
          n_ref_d    = '0;
          n_sig_d    = '0;
          gate_cnt_d = '0;
          state_d    = StMeasure;
        end else if (to_cnt_q == ToLast) begin
          data_fx_d = '0;
          state_d   = StDone;
        end
      end

      StMeasure: begin
        n_ref_d    = n_ref_q + 1'b1;
        gate_cnt_d = gate_cnt_q + 1'b1;
        if (sig_rise_q) begin
          n_sig_d = n_sig_q + 1'b1;
        end
        if (gate_cnt_q == GateLast) begin
          to_cnt_d = '0;
          state_d  = StWaitStop;
        end
      end

      StWaitStop: begin
        n_ref_d  = n_ref_q + 1'b1;
        to_cnt_d = to_cnt_q + 1'b1;
        if (sig_rise_q) begin
          // Closing edge: counts are final including this cycle.
          n_sig_d   = n_sig_q + 1'b1;
`ifdef FREQ_METER_ROUND_EN
          num_d     = 64'(n_sig_d) * 64'(CLK_FREQ) + 64'(n_ref_d >> 1);
`else
          num_d     = 64'(n_sig_d) * 64'(CLK_FREQ);
`endif
          den_d     = n_ref_d;
          rem_d     = '0;
          bit_cnt_d = '0;
          state_d   = StDivide;
        end else if (to_cnt_q == ToLast) begin
          data_fx_d = '0;
          state_d   = StDone;
        end
      end

      StDivide: begin
        num_d     = num_next;
        rem_d     = rem_next;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == 6'd63) begin
          data_fx_d = num_next;
          state_d   = StDone;
        end
      end

      StDone: begin
        to_cnt_d = '0;
        state_d  = StWaitStart;
      end

      default: begin
        state_d = StWaitStart;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StWaitStart;
      sync_q     <= '0;
      sig_rise_q <= 1'b0;
      n_ref_q    <= '0;
      n_sig_q    <= '0;
      gate_cnt_q <= '0;
      to_cnt_q   <= '0;
      num_q      <= '0;
      rem_q      <= '0;
      den_q      <= '0;
      bit_cnt_q  <= '0;
      data_fx_q  <= '0;
    end else begin
      state_q    <= state_d;
      // Two-flop synchronizer plus one history flop for edge detection.
      sync_q     <= {sync_q[1:0], sig_in};
      sig_rise_q <= sync_q[1] & ~sync_q[2];
      n_ref_q    <= n_ref_d;
      n_sig_q    <= n_sig_d;
      gate_cnt_q <= gate_cnt_d;
      to_cnt_q   <= to_cnt_d;
      num_q      <= num_d;
      rem_q      <= rem_d;
      den_q      <= den_d;
      bit_cnt_q  <= bit_cnt_d;
      data_fx_q  <= data_fx_d;
    end
  end

  assign data_fx    = data_fx_q;
  assign data_valid = (state_q == StDone);
  assign busy       = (state_q == StMeasure) || (state_q == StWaitStop) ||
                      (state_q == StDivide);

endmodule
